// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: transmitter FSM state encodings and the bit-period helper.
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clocks per bit; a zero clock rate means one clock per bit for fast simulation.
  function automatic int unsigned baud_div(input int unsigned clk_mhz, input int unsigned baud);
    int unsigned d;
    if (clk_mhz == 0) return 1;
    d = (clk_mhz * 1_000_000) / baud;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Generic synchronous FIFO with registered full/empty; dout is valid whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_n;
  logic             do_push, do_pop;

  // Push is judged against the registered full flag, so a same-cycle pop cannot rescue it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_MHZ    = 12,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_send,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);
  localparam int DIV = baud_div(CLK_MHZ, BAUD);
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_e     state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_dout;
  logic          fifo_pop, bit_done, line_n;
  logic          tx_q, active_q, ovf_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_send),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign bit_done = (cnt == LAST);
  assign uart_tx  = tx_q;
  assign overflow = ovf_q;
  assign busy     = active_q || !tx_empty;

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    line_n   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!tx_empty) begin
          fifo_pop = 1'b1;
          state_n  = ST_START;
        end
      end
      ST_START: begin
        line_n = 1'b0;
        if (bit_done) state_n = ST_DATA;
      end
      ST_DATA: begin
        line_n = shreg[bit_idx];
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_n = ^shreg;
        if (bit_done) state_n = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so queued bytes leave gap-free.
        if (bit_done) begin
          if (!tx_empty) begin
            fifo_pop = 1'b1;
            state_n  = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_n;
      // Line level follows the state one cycle late, so busy tracks the line the same way.
      tx_q     <= line_n;
      active_q <= (state != ST_IDLE) || fifo_pop;
      if (tx_send && tx_full) ovf_q <= 1'b1;
      if (fifo_pop) shreg <= fifo_dout;
      if (state == ST_IDLE || bit_done) cnt <= '0;
      else                              cnt <= cnt + CW'(1);
      if (state == ST_DATA && bit_done) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: two transmitters (1 clk/bit depth 4, 12 clk/bit depth 16) against a queue-based line model.
module tb_uart_tx_buffered;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_send;
  logic [7:0] tx_data;
  int         n_chk = 0;
  int         n_fail = 0;

  logic r0_tx [256];
  logic r0_e  [256];
  logic r0_f  [256];
  logic r0_o  [256];
  logic r0_b  [256];
  logic r1_tx [256];
  logic r1_b  [256];

  always #5 clk = ~clk;

  // Line level of bit slot j of a frame carrying byte b.
  function automatic logic lvl(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int MHZ = (g == 0) ? 0 : 12;
    localparam int DV  = (g == 0) ? 1 : 12;
    localparam int DP  = (g == 0) ? 4 : 16;

    logic       uart_tx, busy, tx_empty, tx_full, overflow;
    logic [4:0] mexp;
    logic [7:0] q[$];
    bit         ln[$];
    bit         ovf_m;

    // Model: bytes queue up; the next frame is committed once the line has at most one
    // cycle of committed output left; levels come out one per cycle. {tx,busy,empty,full,ovf}
    function automatic logic [4:0] step(input logic rst, input logic send, input logic [7:0] d);
      logic [7:0] b;
      bit         was_full, act;
      logic       tx;
      if (rst) begin
        q.delete();
        ln.delete();
        ovf_m = 1'b0;
        return 5'b10100;
      end
      was_full = (q.size() == DP);
      if (ln.size() <= 1 && q.size() > 0) begin
        b = q.pop_front();
        if (ln.size() == 0) ln.push_back(1'b1);
        for (int j = 0; j < NB; j++) repeat (DV) ln.push_back(lvl(b, j));
      end
      if (send) begin
        if (was_full) ovf_m = 1'b1;
        else          q.push_back(d);
      end
      act = (ln.size() > 0);
      tx  = act ? ln.pop_front() : 1'b1;
      return {tx, act || q.size() > 0, q.size() == 0, q.size() == DP, ovf_m};
    endfunction

    always @(posedge clk) mexp <= step(reset, tx_send, tx_data);

    uart_tx_buffered #(.CLK_MHZ(MHZ), .BAUD(1_000_000), .FIFO_DEPTH(DP)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_empty (tx_empty),
      .busy     (busy),
      .overflow (overflow),
      .uart_tx  (uart_tx)
    );
  end

  task automatic chk(input string nm, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, expv);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Advance to the next falling edge and compare both DUTs with the model.
  task automatic tick();
    @(negedge clk);
    chk("m0_uart_tx",  mdl[0].uart_tx,  mdl[0].mexp[4]);
    chk("m0_busy",     mdl[0].busy,     mdl[0].mexp[3]);
    chk("m0_tx_empty", mdl[0].tx_empty, mdl[0].mexp[2]);
    chk("m0_tx_full",  mdl[0].tx_full,  mdl[0].mexp[1]);
    chk("m0_overflow", mdl[0].overflow, mdl[0].mexp[0]);
    chk("m1_uart_tx",  mdl[1].uart_tx,  mdl[1].mexp[4]);
    chk("m1_busy",     mdl[1].busy,     mdl[1].mexp[3]);
    chk("m1_tx_empty", mdl[1].tx_empty, mdl[1].mexp[2]);
    chk("m1_tx_full",  mdl[1].tx_full,  mdl[1].mexp[1]);
    chk("m1_overflow", mdl[1].overflow, mdl[1].mexp[0]);
  endtask

  task automatic sample(input int k);
    r0_tx[k] = mdl[0].uart_tx;
    r0_e[k]  = mdl[0].tx_empty;
    r0_f[k]  = mdl[0].tx_full;
    r0_o[k]  = mdl[0].overflow;
    r0_b[k]  = mdl[0].busy;
    r1_tx[k] = mdl[1].uart_tx;
    r1_b[k]  = mdl[1].busy;
  endtask

  task automatic wait_idle(input int max);
    int c = 0;
    while ((mdl[0].busy || mdl[1].busy) && c < max) begin
      tick();
      c++;
    end
    chk("idle_reached", mdl[0].busy || mdl[1].busy, 1'b0);
    tick();
  endtask

  initial begin
    logic [7:0] b;
    int cnt, k0, z;
    reset   = 1'b1;
    tx_send = 1'b0;
    tx_data = 8'h00;
    repeat (3) tick();
    chk("rst_uart_tx",  mdl[0].uart_tx,  1'b1);
    chk("rst_tx_full",  mdl[0].tx_full,  1'b0);
    chk("rst_tx_empty", mdl[0].tx_empty, 1'b1);
    chk("rst_busy",     mdl[0].busy,     1'b0);
    chk("rst_overflow", mdl[0].overflow, 1'b0);
    reset = 1'b0;
    tick();

    // Single 0x55 at one clock per bit.
    b = 8'h55;
    tx_data = b;
    tx_send = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tx_send = 1'b0;
      sample(k);
    end
    chk("t1_empty_k1", r0_e[1], 1'b0);
    chk("t1_idle_k2", r0_tx[2], 1'b1);
    chk("t1_start_k3", r0_tx[3], 1'b0);
    for (int i = 0; i < 8; i++) chk("t1_data", r0_tx[4+i], b[i]);
    chk("t1_stop", r0_tx[NB+2], 1'b1);
    chk("t1_busy_in_stop", r0_b[NB+2], 1'b1);
    chk("t1_busy_drop", r0_b[NB+3], 1'b0);
    wait_idle(400);

    // 0xA3 at 12 clocks per bit.
    b = 8'hA3;
    tx_data = b;
    tx_send = 1'b1;
    for (int k = 1; k <= 12*NB + 10; k++) begin
      tick();
      tx_send = 1'b0;
      sample(k);
    end
    k0 = 0;
    for (int k = 1; k <= 20; k++) if (r1_tx[k] == 1'b0 && k0 == 0) k0 = k;
    chk_int("t2_latency", k0, 3);
    for (int j = 0; j < NB; j++) begin
      cnt = 0;
      for (int c = 0; c < 12; c++) if (r1_tx[3 + 12*j + c] === lvl(b, j)) cnt++;
      chk_int("t2_bit_len", cnt, 12);
    end
    chk("t2_busy_last", r1_b[2 + 12*NB], 1'b1);
    chk("t2_busy_drop", r1_b[3 + 12*NB], 1'b0);
    chk("t2_line_idle", r1_tx[3 + 12*NB], 1'b1);
    wait_idle(400);

    // Burst of three: frames must abut.
    tx_send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h41 + 8'(i);
      tick();
      sample(i + 1);
    end
    tx_send = 1'b0;
    for (int k = 4; k <= 3*NB + 6; k++) begin
      tick();
      sample(k);
    end
    chk("t3_empty_before_pop3", r0_e[2*NB+1], 1'b0);
    chk("t3_empty_at_pop3", r0_e[2*NB+2], 1'b1);
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      for (int j = 0; j < NB; j++) if (r0_tx[3 + f*NB + j] === lvl(8'h41 + 8'(f), j)) cnt++;
      chk_int("t3_frame", cnt, NB);
    end
    chk("t3_idle_after", r0_tx[3 + 3*NB], 1'b1);
    wait_idle(1000);

    // Six writes into a depth-4 FIFO: five fit, one is dropped.
    tx_send = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h10 + 8'(i);
      tick();
      sample(i + 1);
    end
    tx_send = 1'b0;
    for (int k = 7; k <= 6*NB + 10; k++) begin
      tick();
      sample(k);
    end
    chk("t4_full_k4", r0_f[4], 1'b0);
    chk("t4_full_k5", r0_f[5], 1'b1);
    chk("t4_ovf_k5", r0_o[5], 1'b0);
    chk("t4_ovf_k6", r0_o[6], 1'b1);
    chk("t4_ovf_sticky", r0_o[6*NB+10], 1'b1);
    for (int f = 0; f < 5; f++) begin
      cnt = 0;
      for (int j = 0; j < NB; j++) if (r0_tx[3 + f*NB + j] === lvl(8'h10 + 8'(f), j)) cnt++;
      chk_int("t4_frame", cnt, NB);
    end
    z = 0;
    for (int k = 3 + 5*NB; k <= 6*NB + 10; k++) if (r0_tx[k] !== 1'b1) z++;
    chk_int("t4_no_extra_frame", z, 0);
    wait_idle(1500);

    // Reset during bit 4 with two bytes still queued.
    tx_send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h81 + 8'(i);
      tick();
    end
    tx_send = 1'b0;
    repeat (5) tick();
    chk("t5_bit4", mdl[0].uart_tx, 1'b0);
    chk("t5_ovf_before", mdl[0].overflow, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_uart_tx", mdl[0].uart_tx, 1'b1);
    chk("t5_empty", mdl[0].tx_empty, 1'b1);
    chk("t5_busy", mdl[0].busy, 1'b0);
    chk("t5_overflow", mdl[0].overflow, 1'b0);
    z = 0;
    repeat (40) begin
      tick();
      if (mdl[0].uart_tx !== 1'b1) z++;
    end
    chk_int("t5_no_frames", z, 0);

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07;
    tx_send = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tx_send = 1'b0;
      sample(k);
    end
    chk("t6_parity_07", r0_tx[12], 1'b1);
    chk("t6_stop_07", r0_tx[13], 1'b1);
    chk("t6_busy_07", r0_b[13], 1'b1);
    chk("t6_busy_drop_07", r0_b[14], 1'b0);
    wait_idle(400);
    tx_data = 8'h03;
    tx_send = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tx_send = 1'b0;
      sample(k);
    end
    chk("t6_parity_03", r0_tx[12], 1'b0);
    wait_idle(400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
